// File: rtl/ahb_cmd_arb.sv
// Round-robin arbiter sharing one AHB master command port between NREQ requesters.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_cmd_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDRW     = 32,
    parameter int unsigned DATAW     = 32,
    parameter int unsigned BYTE_CNTW = 16,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             wr,
    input  logic [NREQ*ADDRW-1:0]       start_addr,
    input  logic [NREQ*BYTE_CNTW-1:0]   byte_cnt,
    input  logic [NREQ*DATAW-1:0]       wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     owner,
    output logic                        err,
    output logic                        m_req,
    output logic                        m_wr,
    output logic [ADDRW-1:0]            m_start_addr,
    output logic [BYTE_CNTW-1:0]        m_byte_cnt,
    output logic [DATAW-1:0]            m_wdata,
    input  logic                        m_ack,
    input  logic                        m_done
);

    localparam int unsigned PTRW = $clog2(NREQ);
    localparam int unsigned CNTW = 16;

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 2) begin : g_bad_cfg
        $error("ahb_cmd_arb: unsupported NREQ or TO_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ZDONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PTRW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]        owner_q, owner_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   m_req_q, m_req_d;
    logic                   wr_q, wr_d;
    logic [ADDRW-1:0]       addr_q, addr_d;
    logic [BYTE_CNTW-1:0]   cnt_bytes_q, cnt_bytes_d;
    logic [DATAW-1:0]       wdata_q, wdata_d;

    logic                   win_vld;
    logic [PTRW-1:0]        win_idx;
    int unsigned            cand;
    logic [PTRW-1:0]        cand_idx;
    logic [BYTE_CNTW-1:0]   win_cnt;

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = PTRW'(cand);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    assign win_cnt = byte_cnt[32'(win_idx)*BYTE_CNTW +: BYTE_CNTW];

`ifdef ARB_TIMEOUT_EN
    logic [CNTW-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        done_d      = '0;
        m_req_d     = 1'b0;
        wr_d        = wr_q;
        addr_d      = addr_q;
        cnt_bytes_d = cnt_bytes_q;
        wdata_d     = wdata_q;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d    = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    rr_ptr_d       = (win_idx == PTRW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                    wr_d           = wr[win_idx];
                    addr_d         = start_addr[32'(win_idx)*ADDRW +: ADDRW];
                    cnt_bytes_d    = win_cnt;
                    wdata_d        = wdata[32'(win_idx)*DATAW +: DATAW];
                    state_d        = (win_cnt == '0) ? ST_ZDONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // m_done here belongs to nobody; only the ack matters
                m_req_d = 1'b1;
                if (m_req_q && m_ack) begin
                    m_req_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == CNTW'(TO_CYCLES-1)) begin
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_ZDONE: begin
                done_d[owner_q] = 1'b1;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || (done_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            m_req_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            cnt_bytes_q <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            m_req_q     <= m_req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            cnt_bytes_q <= cnt_bytes_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign m_req        = m_req_q;
    assign m_wr         = wr_q;
    assign m_start_addr = addr_q;
    assign m_byte_cnt   = cnt_bytes_q;
    assign m_wdata      = wdata_q;

endmodule

// File: tb/tb_ahb_cmd_arb.sv
// Directed self-checking bench for ahb_cmd_arb (NREQ=4, TO_CYCLES=16).
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_ahb_cmd_arb;

    localparam int unsigned NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req = '0;
    logic [3:0]        wr  = '0;
    logic [127:0]      start_addr = '0;
    logic [63:0]       byte_cnt   = '0;
    logic [127:0]      wdata      = '0;
    logic [3:0]        gnt, done;
    logic              busy, err;
    logic [1:0]        owner;
    logic              m_req, m_wr;
    logic [31:0]       m_start_addr, m_wdata;
    logic [15:0]       m_byte_cnt;
    logic              m_ack  = 1'b0;
    logic              m_done = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    ahb_cmd_arb #(
        .NREQ(NREQ), .ADDRW(32), .DATAW(32), .BYTE_CNTW(16), .TO_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .start_addr(start_addr),
        .byte_cnt(byte_cnt), .wdata(wdata), .gnt(gnt), .done(done), .busy(busy),
        .owner(owner), .err(err), .m_req(m_req), .m_wr(m_wr),
        .m_start_addr(m_start_addr), .m_byte_cnt(m_byte_cnt), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_done(m_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [31:0] a,
                           input logic [15:0] c, input logic [31:0] d);
        wr[i]               = w;
        start_addr[i*32 +: 32] = a;
        byte_cnt[i*16 +: 16]   = c;
        wdata[i*32 +: 32]      = d;
    endtask

    // Wait (bounded) for a grant, then run ack/done handshake for requester idx
    task automatic serve(input int idx, input logic [31:0] exp_addr);
        int k;
        k = 0;
        step();
        while (gnt == '0 && k < 8) begin
            step();
            k++;
        end
        chk("rr_gnt", 64'(gnt), 64'(1) << idx);
        chk("rr_owner", 64'(owner), 64'(idx));
        step();
        chk("rr_mreq", 64'(m_req), 64'd1);
        chk("rr_addr", 64'(m_start_addr), 64'(exp_addr));
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("rr_done", 64'(done), 64'(1) << idx);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_mreq", 64'(m_req), 64'd0);
        chk("rst_addr", 64'(m_start_addr), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        step();

        // Single request on requester 2
        set_cmd(2, 1'b1, 32'h1000_0040, 16'd64, 32'hdead_beef);
        req = 4'b0100;
        step();
        chk("t1_gnt", 64'(gnt), 64'h4);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_owner", 64'(owner), 64'd2);
        chk("t1_mreq_lat", 64'(m_req), 64'd0);
        req = 4'b0000;
        step();
        chk("t1_gnt_pulse", 64'(gnt), 64'd0);
        chk("t1_mreq", 64'(m_req), 64'd1);
        chk("t1_addr", 64'(m_start_addr), 64'h1000_0040);
        chk("t1_cnt", 64'(m_byte_cnt), 64'd64);
        chk("t1_wr", 64'(m_wr), 64'd1);
        chk("t1_wdata", 64'(m_wdata), 64'hdead_beef);
        step();
        chk("t1_mreq_hold", 64'(m_req), 64'd1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("t1_mreq_drop", 64'(m_req), 64'd0);
        step();
        chk("t1_wait_nodone", 64'(done), 64'd0);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("t1_done", 64'(done), 64'h4);
        chk("t1_busy_done", 64'(busy), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        step();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_busy_fall", 64'(busy), 64'd0);
        chk("t1_owner_keep", 64'(owner), 64'd2);

        // Round-robin from a fresh reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            set_cmd(i, 1'(i), 32'h2000_0000 + 32'(i) * 32'h100, 16'(16 * (i + 1)), 32'(i));
        req = 4'b1111;
        serve(0, 32'h2000_0000);
        serve(1, 32'h2000_0100);
        serve(2, 32'h2000_0200);
        serve(3, 32'h2000_0300);
        req = 4'b1001;
        serve(0, 32'h2000_0000);
        serve(3, 32'h2000_0300);
        serve(0, 32'h2000_0000);
        req = 4'b0000;
        step();
        chk("t2_idle_busy", 64'(busy), 64'd0);

        // Zero byte count completes without a downstream command
        set_cmd(1, 1'b0, 32'h3000_0000, 16'd0, 32'h0);
        req = 4'b0010;
        step();
        chk("t3_gnt", 64'(gnt), 64'h2);
        chk("t3_cnt", 64'(m_byte_cnt), 64'd0);
        req = 4'b0000;
        step();
        chk("t3_done", 64'(done), 64'h2);
        chk("t3_mreq", 64'(m_req), 64'd0);
        step();
        chk("t3_mreq_after", 64'(m_req), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);

        // Late m_done in IDLE has no effect
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        step();
        chk("idle_mdone", 64'(done), 64'd0);

        // m_ack and m_done together in ISSUE; m_done alone in ISSUE ignored
        set_cmd(3, 1'b0, 32'h4000_0010, 16'd8, 32'h0);
        req = 4'b1000;
        step();
        chk("t6_gnt", 64'(gnt), 64'h8);
        req = 4'b0000;
        step();
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("t6_issue_mdone", 64'(done), 64'd0);
        chk("t6_issue_hold", 64'(m_req), 64'd1);
        m_ack = 1'b1;
        m_done = 1'b1;
        step();
        m_ack = 1'b0;
        m_done = 1'b0;
        chk("t6_nodone", 64'(done), 64'd0);
        chk("t6_mreq", 64'(m_req), 64'd0);
`ifndef ARB_TIMEOUT_EN
        for (int i = 0; i < 20; i++) step();
        chk("t6_wait_hold", 64'(done), 64'd0);
`endif
        step();
        chk("t6_busy", 64'(busy), 64'd1);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("t6_done", 64'(done), 64'h8);
        step();

        // Reset during WAIT with rr_ptr moved away from 0
        set_cmd(1, 1'b1, 32'h5000_0000, 16'd4, 32'h0);
        req = 4'b0010;
        step();
        chk("t4_gnt", 64'(gnt), 64'h2);
        req = 4'b0000;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("t4_mreq", 64'(m_req), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_gnt_rst", 64'(gnt), 64'd0);
        chk("t4_done_rst", 64'(done), 64'd0);
        chk("t4_owner", 64'(owner), 64'd0);
        set_cmd(2, 1'b0, 32'h5000_0200, 16'd4, 32'h0);
        req = 4'b0110;
        step();
        chk("t4_done_hold", 64'(done), 64'd0);
        rst = 1'b1;
        step();
        chk("t4_first_gnt", 64'(gnt), 64'h2);
        req = 4'b0000;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("t4_done", 64'(done), 64'h2);
        step();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no m_done after 16 WAIT cycles
        set_cmd(0, 1'b0, 32'h6000_0000, 16'd4, 32'h0);
        req = 4'b0001;
        step();
        chk("t5_gnt", 64'(gnt), 64'h1);
        req = 4'b0000;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("t5_pre_done", 64'(done), 64'd0);
        chk("t5_pre_err", 64'(err), 64'd0);
        step();
        chk("t5_done", 64'(done), 64'h1);
        chk("t5_err", 64'(err), 64'd1);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("t5_err_pulse", 64'(err), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        step();
        chk("t5_late_done", 64'(done), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
